cpu_bus_ctrl: RTL and testbench
===============================

CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

Interface
REQ-001 SHALL have parameter DMA_LEN, default 256, meaning the number of bytes moved per OAM DMA transfer (1..256).
REQ-002 SHALL have parameter RAM_ABITS, default 11, meaning the system RAM address width; RAM mirrors through $0000-$1FFF.
REQ-003 SHALL have parameter DMA_REG, default 16'h4014, meaning the DMA trigger register address.
REQ-004 SHALL have port Clk, input, 1 bit: the single system clock; one CPU cycle equals one Clk cycle with CPU_CE high.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port CPU_CE, input, 1 bit: CPU cycle enable; all state advances only when it is high.
REQ-007 SHALL have port CPU_ADDR, input, 16 bits: CPU address.
REQ-008 SHALL have port CPU_WR, input, 1 bit: 1 = read cycle, 0 = write cycle.
REQ-009 SHALL have port CPU_DO, input, 8 bits: CPU write data.
REQ-010 SHALL have ports SYSRAM_Q, PRGROM_Q, CONTROL1, CONTROL2 and VIDEO_BUS, each input, 8 bits: the source read data.
REQ-011 SHALL have port BUS_OUT, output, 8 bits: resolved data-bus value.
REQ-012 SHALL have port INT_ADDR, output, 16 bits: effective address, which is the DMA address while DMA owns the bus, else CPU_ADDR.
REQ-013 SHALL have port SYSRAM_ADDR, output, RAM_ABITS bits: INT_ADDR[RAM_ABITS-1:0].
REQ-014 SHALL have ports SYSRAM_EN, CONTROL1_EN, CONTROL2_EN and VIDEO_EN, each output, 1 bit: region write/strobe enables.
REQ-015 SHALL have port CPU_RDY, output, 1 bit: low stalls the CPU.
REQ-016 SHALL have ports OAM_WE (output, 1 bit), OAM_ADDR (output, 8 bits) and OAM_DATA (output, 8 bits): the OAM write port.

Function
REQ-017 SHALL decode INT_ADDR as follows: $0000-$1FFF RAM; $2000-$3FFF video (mirrored every 8); $4016 CONTROL1; $4017 CONTROL2; $8000-$FFFF PRGROM; everything else unmapped.
REQ-018 SHALL, on a read, drive BUS_OUT with the selected source, and on a write, drive it with CPU_DO.
REQ-019 SHALL assert the write-enable of the decoded region only on a write; PRGROM writes are ignored.
REQ-020 SHALL implement an FSM with states IDLE, ALIGN, RD, WR.
REQ-021 SHALL latch page = CPU_DO on a CPU write to DMA_REG in IDLE with CPU_CE high, and move to ALIGN.
REQ-022 SHALL drop CPU_RDY in the cycle after the trigger write and hold it low until DMA returns to IDLE.
REQ-023 SHALL spend 1 CPU cycle in ALIGN, plus 1 more if the trigger write occurred on an odd CPU cycle (free-running 1-bit parity counter).
REQ-024 SHALL, in RD, drive INT_ADDR={page, idx} with CPU_WR treated as read, and capture BUS_OUT into the data register.
REQ-025 SHALL, in WR, pulse OAM_WE for one CPU cycle, with OAM_ADDR=idx and OAM_DATA equal to the captured byte.
REQ-026 SHALL, after WR, increment idx; if idx==DMA_LEN-1, return to IDLE, else go to RD.
REQ-027 SHALL make a full transfer take 2*DMA_LEN+1 or 2*DMA_LEN+2 CPU cycles.
REQ-028 SHALL ignore CPU bus activity while DMA is active, and ignore DMA_REG writes that arrive while not in IDLE.
REQ-029 SHALL allow a page of $40-$5F, reading unmapped/open-bus values with no controller strobe side effects (CONTROLx_EN held low during DMA).
REQ-030 SHALL hold all state whenever CPU_CE is low.

Reset
REQ-031 SHALL, on Reset, force the FSM to IDLE, idx=0, page=0, parity=0 and the open-bus latch=0.
REQ-032 SHALL hold outputs during reset at CPU_RDY=1, OAM_WE=0, all *_EN=0 and BUS_OUT=0.
REQ-033 SHALL abort a DMA mid-transfer on Reset, with no further OAM writes.

Configuration
REQ-034 SHALL, with macro CPU_BUS_OPEN_BUS_EN defined, keep a register of the last BUS_OUT value and return it for unmapped reads and for $4016/$4017 bits 7:5.
REQ-035 SHALL, with CPU_BUS_OPEN_BUS_EN undefined, return 8'h00 for unmapped reads and leave controller reads unmodified.

Structure
REQ-036 SHALL place in package nes_bus_pkg: the dma_state_t enum, region_t enum and address constants (RAM_END, VIDEO_BASE, CTRL1_ADDR, CTRL2_ADDR, PRG_BASE).
REQ-037 SHALL use sub-module oam_dma (FSM, idx, page, parity), with decode/mux in the top module.

Verification
REQ-038 SHALL verify: write $0812=8'hA5 -> SYSRAM_EN=1, SYSRAM_ADDR=11'h012, BUS_OUT=8'hA5.
REQ-039 SHALL verify: read $3FFA with VIDEO_BUS=8'h3C -> BUS_OUT=8'h3C, no enables asserted.
REQ-040 SHALL verify: write $4014=8'h02 on an even cycle -> CPU_RDY low for 513 cycles; OAM receives bytes from RAM $0200-$02FF at OAM_ADDR 0-255.
REQ-041 SHALL verify: the same trigger on an odd cycle -> CPU_RDY low for exactly 514 cycles.
REQ-042 SHALL verify: Reset asserted at idx=8'h40 -> next cycle FSM IDLE, CPU_RDY=1, OAM_WE=0.
REQ-043 SHALL verify: read $5000 after a read returning 8'h7E -> BUS_OUT=8'h7E with CPU_BUS_OPEN_BUS_EN, 8'h00 without.

Source files
------------

// File: rtl/cpu_bus_ctrl_pkg.sv
// Shared types and address map for the CPU bus controller and its OAM DMA engine.
package nes_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RD    = 2'd2,
    WR    = 2'd3
  } dma_state_t;

  typedef enum logic [2:0] {
    REG_NONE  = 3'd0,
    REG_RAM   = 3'd1,
    REG_VIDEO = 3'd2,
    REG_CTRL1 = 3'd3,
    REG_CTRL2 = 3'd4,
    REG_PRG   = 3'd5
  } region_t;

  localparam logic [15:0] RAM_END    = 16'h1FFF;
  localparam logic [15:0] VIDEO_BASE = 16'h2000;
  localparam logic [15:0] VIDEO_END  = 16'h3FFF;
  localparam logic [15:0] CTRL1_ADDR = 16'h4016;
  localparam logic [15:0] CTRL2_ADDR = 16'h4017;
  localparam logic [15:0] PRG_BASE   = 16'h8000;

  // RAM and video registers are mirrored, so only the region matters here;
  // the low address bits go out untouched for the targets to use.
  function automatic region_t decode_region(input logic [15:0] addr);
    if (addr <= RAM_END)
      return REG_RAM;
    else if (addr >= VIDEO_BASE && addr <= VIDEO_END)
      return REG_VIDEO;
    else if (addr == CTRL1_ADDR)
      return REG_CTRL1;
    else if (addr == CTRL2_ADDR)
      return REG_CTRL2;
    else if (addr >= PRG_BASE)
      return REG_PRG;
    else
      return REG_NONE;
  endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// CPU-side bus bundle: CPU request, source read data, region strobes and OAM write port.
interface cpu_bus_if #(
  parameter int RAM_ABITS = 11
);
  logic                 CPU_CE;
  logic [15:0]          CPU_ADDR;
  logic                 CPU_WR;
  logic [7:0]           CPU_DO;
  logic [7:0]           SYSRAM_Q;
  logic [7:0]           PRGROM_Q;
  logic [7:0]           CONTROL1;
  logic [7:0]           CONTROL2;
  logic [7:0]           VIDEO_BUS;
  logic [7:0]           BUS_OUT;
  logic [15:0]          INT_ADDR;
  logic [RAM_ABITS-1:0] SYSRAM_ADDR;
  logic                 SYSRAM_EN;
  logic                 CONTROL1_EN;
  logic                 CONTROL2_EN;
  logic                 VIDEO_EN;
  logic                 CPU_RDY;
  logic                 OAM_WE;
  logic [7:0]           OAM_ADDR;
  logic [7:0]           OAM_DATA;

  modport master (
    output CPU_CE, CPU_ADDR, CPU_WR, CPU_DO,
    output SYSRAM_Q, PRGROM_Q, CONTROL1, CONTROL2, VIDEO_BUS,
    input  BUS_OUT, INT_ADDR, SYSRAM_ADDR,
    input  SYSRAM_EN, CONTROL1_EN, CONTROL2_EN, VIDEO_EN,
    input  CPU_RDY, OAM_WE, OAM_ADDR, OAM_DATA
  );

  modport slave (
    input  CPU_CE, CPU_ADDR, CPU_WR, CPU_DO,
    input  SYSRAM_Q, PRGROM_Q, CONTROL1, CONTROL2, VIDEO_BUS,
    output BUS_OUT, INT_ADDR, SYSRAM_ADDR,
    output SYSRAM_EN, CONTROL1_EN, CONTROL2_EN, VIDEO_EN,
    output CPU_RDY, OAM_WE, OAM_ADDR, OAM_DATA
  );
endinterface

// File: rtl/cpu_bus_ctrl_oam_dma.sv
// OAM DMA engine: sequences page-sized copies from the CPU bus into OAM.
//
//  state | meaning
//  IDLE  | CPU owns the bus, watching for a write to the DMA trigger register
//  ALIGN | CPU stalled; one cycle, or two if triggered on an odd cycle
//  RD    | DMA drives {page, idx} and captures the resolved bus byte
//  WR    | OAM_WE pulses with the captured byte at OAM_ADDR = idx
module oam_dma
  import nes_bus_pkg::*;
#(
  parameter int          DMA_LEN = 256,
  parameter logic [15:0] DMA_REG = 16'h4014
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_ce,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_do,
  input  logic [7:0]  bus_data,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        cpu_rdy,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state;
  logic [7:0] idx;
  logic [7:0] page;
  logic [7:0] data_q;
  logic       parity;
  logic       align_extra;
  logic       rdy_q;
  logic       we_q;

  // Transfer sequencer; everything holds while the CPU clock enable is low.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      idx         <= 8'h00;
      page        <= 8'h00;
      data_q      <= 8'h00;
      parity      <= 1'b0;
      align_extra <= 1'b0;
      rdy_q       <= 1'b1;
      we_q        <= 1'b0;
    end else if (cpu_ce) begin
      parity <= ~parity;
      we_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (!cpu_wr && cpu_addr == DMA_REG) begin
            page        <= cpu_do;
            align_extra <= parity;
            rdy_q       <= 1'b0;
            state       <= ALIGN;
          end
        end
        ALIGN: begin
          if (align_extra)
            align_extra <= 1'b0;
          else
            state <= RD;
        end
        RD: begin
          data_q <= bus_data;
          we_q   <= 1'b1;
          state  <= WR;
        end
        WR: begin
          if (idx == LAST_IDX) begin
            idx   <= 8'h00;
            rdy_q <= 1'b1;
            state <= IDLE;
          end else begin
            idx   <= idx + 8'd1;
            state <= RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dma_active = (state != IDLE);
  assign dma_addr   = {page, idx};
  assign oam_addr   = idx;
  assign oam_data   = data_q;
  // Reset overrides the registered handshake so the CPU is never stalled
  // and OAM is never written while reset is held.
  assign cpu_rdy    = rdy_q | Reset;
  assign oam_we     = we_q & ~Reset;

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU bus controller: address decode, read-data mux, region strobes and OAM DMA.
// Optional macro CPU_BUS_OPEN_BUS_EN keeps the last bus value and returns it
// for unmapped reads and the unused upper bits of the controller ports.
module cpu_bus_ctrl
  import nes_bus_pkg::*;
#(
  parameter int          DMA_LEN   = 256,
  parameter int          RAM_ABITS = 11,
  parameter logic [15:0] DMA_REG   = 16'h4014
) (
  input logic       Clk,
  input logic       Reset,
  cpu_bus_if.slave  bus
);

  logic        dma_active;
  logic [15:0] dma_addr;
  logic [15:0] int_addr;
  region_t     region;
  logic        cpu_write;
  logic        strobe;
  logic [7:0]  rd_data;
  logic [7:0]  bus_out;
  logic [7:0]  open_bus;

  oam_dma #(
    .DMA_LEN (DMA_LEN),
    .DMA_REG (DMA_REG)
  ) u_oam_dma (
    .Clk        (Clk),
    .Reset      (Reset),
    .cpu_ce     (bus.CPU_CE),
    .cpu_addr   (bus.CPU_ADDR),
    .cpu_wr     (bus.CPU_WR),
    .cpu_do     (bus.CPU_DO),
    .bus_data   (bus_out),
    .dma_active (dma_active),
    .dma_addr   (dma_addr),
    .cpu_rdy    (bus.CPU_RDY),
    .oam_we     (bus.OAM_WE),
    .oam_addr   (bus.OAM_ADDR),
    .oam_data   (bus.OAM_DATA)
  );

  // DMA owns the bus for the whole transfer and always reads; the CPU is ignored.
  assign int_addr  = dma_active ? dma_addr : bus.CPU_ADDR;
  assign region    = decode_region(int_addr);
  assign cpu_write = !dma_active && !bus.CPU_WR;
  assign strobe    = cpu_write && bus.CPU_CE && !Reset;

`ifdef CPU_BUS_OPEN_BUS_EN
  logic [7:0] open_bus_q;

  // Last value driven on the data bus, replayed on reads nobody answers.
  always_ff @(posedge Clk) begin
    if (Reset)
      open_bus_q <= 8'h00;
    else if (bus.CPU_CE)
      open_bus_q <= bus_out;
  end

  assign open_bus = open_bus_q;
`else
  assign open_bus = 8'h00;
`endif

  // Read-data source select.
  always_comb begin
    rd_data = open_bus;
    case (region)
      REG_RAM:   rd_data = bus.SYSRAM_Q;
      REG_VIDEO: rd_data = bus.VIDEO_BUS;
`ifdef CPU_BUS_OPEN_BUS_EN
      REG_CTRL1: rd_data = {open_bus[7:5], bus.CONTROL1[4:0]};
      REG_CTRL2: rd_data = {open_bus[7:5], bus.CONTROL2[4:0]};
`else
      REG_CTRL1: rd_data = bus.CONTROL1;
      REG_CTRL2: rd_data = bus.CONTROL2;
`endif
      REG_PRG:   rd_data = bus.PRGROM_Q;
      default:   rd_data = open_bus;
    endcase
  end

  assign bus_out = Reset ? 8'h00 : (cpu_write ? bus.CPU_DO : rd_data);

  assign bus.BUS_OUT     = bus_out;
  assign bus.INT_ADDR    = int_addr;
  assign bus.SYSRAM_ADDR = int_addr[RAM_ABITS-1:0];
  // PRGROM has no enable, so writes there fall on the floor.
  assign bus.SYSRAM_EN   = strobe && (region == REG_RAM);
  assign bus.VIDEO_EN    = strobe && (region == REG_VIDEO);
  assign bus.CONTROL1_EN = strobe && (region == REG_CTRL1);
  assign bus.CONTROL2_EN = strobe && (region == REG_CTRL2);

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl: decode, open bus, OAM DMA timing/data, reset abort.
module tb_cpu_bus_ctrl;

  logic Clk = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;
  int   oam_writes = 0;
  logic [7:0] oam_mem [256];

  cpu_bus_if #(.RAM_ABITS(11)) bus();

  cpu_bus_ctrl #(
    .DMA_LEN   (256),
    .RAM_ABITS (11),
    .DMA_REG   (16'h4014)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] ram_val(input logic [10:0] a);
    return 8'(a[7:0] * 8'd5) ^ {5'd0, a[10:8]} ^ 8'h11;
  endfunction

  always_comb bus.SYSRAM_Q = ram_val(bus.SYSRAM_ADDR);

  always @(negedge Clk) begin
    if (bus.OAM_WE === 1'b1) begin
      oam_mem[bus.OAM_ADDR] = bus.OAM_DATA;
      oam_writes++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu(input logic wr, input logic [15:0] a, input logic [7:0] d);
    bus.CPU_WR   = wr;
    bus.CPU_ADDR = a;
    bus.CPU_DO   = d;
  endtask

  function automatic logic [3:0] enables();
    return {bus.SYSRAM_EN, bus.VIDEO_EN, bus.CONTROL1_EN, bus.CONTROL2_EN};
  endfunction

  task automatic run_dma(input int pre_idle, input string tag, input int exp_low);
    int  low;
    int  bad;
    bit  done;
    Reset = 1'b1;
    cpu(1'b1, 16'h0000, 8'h00);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (pre_idle) @(negedge Clk);
    for (int k = 0; k < 256; k++) oam_mem[k] = 8'hxx;
    oam_writes = 0;
    cpu(1'b0, 16'h4014, 8'h02);
    low  = 0;
    done = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge Clk);
      if (i == 0) cpu(1'b1, 16'h0000, 8'h00);
      if (bus.CPU_RDY === 1'b1) begin
        done = 1'b1;
        break;
      end
      low++;
      if (i == 100) begin
        cpu(1'b0, 16'h4014, 8'h03);
        #1;
        check({tag, "_cpu_write_ignored_en"}, {28'd0, enables()}, 32'd0);
      end
      if (i == 102) cpu(1'b1, 16'h0000, 8'h00);
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_rdy_low_cycles"}, low, exp_low);
    check({tag, "_oam_writes"}, oam_writes, 256);
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (oam_mem[k] !== ram_val(11'h200 | 11'(k))) bad++;
    check({tag, "_oam_bad_bytes"}, bad, 0);
    check({tag, "_oam_first"}, {24'd0, oam_mem[0]}, {24'd0, ram_val(11'h200)});
    check({tag, "_oam_last"}, {24'd0, oam_mem[255]}, {24'd0, ram_val(11'h2FF)});
  endtask

  initial begin
    bit found;
    Reset         = 1'b1;
    bus.CPU_CE    = 1'b1;
    bus.PRGROM_Q  = 8'h00;
    bus.CONTROL1  = 8'h00;
    bus.CONTROL2  = 8'h00;
    bus.VIDEO_BUS = 8'h00;
    cpu(1'b0, 16'h0000, 8'hAA);

    // Reset: outputs forced idle even with a RAM write presented
    @(negedge Clk);
    #1;
    check("rst_cpu_rdy", {31'd0, bus.CPU_RDY}, 32'd1);
    check("rst_oam_we", {31'd0, bus.OAM_WE}, 32'd0);
    check("rst_enables", {28'd0, enables()}, 32'd0);
    check("rst_bus_out", {24'd0, bus.BUS_OUT}, 32'h00);

    // CE low: a trigger write must not advance anything
    @(negedge Clk);
    Reset      = 1'b0;
    bus.CPU_CE = 1'b0;
    cpu(1'b0, 16'h4014, 8'h02);
    @(negedge Clk);
    @(negedge Clk);
    check("ce_low_hold_rdy", {31'd0, bus.CPU_RDY}, 32'd1);
    check("ce_low_hold_int_addr", {16'd0, bus.INT_ADDR}, 32'h4014);
    bus.CPU_CE = 1'b1;
    cpu(1'b1, 16'h0000, 8'h00);
    @(negedge Clk);

    // Decode and data mux
    cpu(1'b0, 16'h0812, 8'hA5);
    #1;
    check("wr0812_sysram_en", {31'd0, bus.SYSRAM_EN}, 32'd1);
    check("wr0812_sysram_addr", {21'd0, bus.SYSRAM_ADDR}, 32'h012);
    check("wr0812_bus_out", {24'd0, bus.BUS_OUT}, 32'hA5);
    @(negedge Clk);
    bus.VIDEO_BUS = 8'h3C;
    cpu(1'b1, 16'h3FFA, 8'h00);
    #1;
    check("rd3ffa_bus_out", {24'd0, bus.BUS_OUT}, 32'h3C);
    check("rd3ffa_enables", {28'd0, enables()}, 32'd0);
    @(negedge Clk);
    cpu(1'b0, 16'h2001, 8'h11);
    #1;
    check("wr2001_enables", {28'd0, enables()}, 32'b0100);
    @(negedge Clk);
    cpu(1'b0, 16'h4016, 8'h01);
    #1;
    check("wr4016_enables", {28'd0, enables()}, 32'b0010);
    @(negedge Clk);
    cpu(1'b0, 16'h4017, 8'h00);
    #1;
    check("wr4017_enables", {28'd0, enables()}, 32'b0001);
    @(negedge Clk);
    cpu(1'b0, 16'h8000, 8'h55);
    #1;
    check("wr8000_enables", {28'd0, enables()}, 32'd0);
    @(negedge Clk);
    cpu(1'b1, 16'h0005, 8'h00);
    #1;
    check("rd0005_bus_out", {24'd0, bus.BUS_OUT}, {24'd0, ram_val(11'h005)});
    @(negedge Clk);

    // Open bus behaviour
    bus.PRGROM_Q = 8'h7E;
    cpu(1'b1, 16'h8000, 8'h00);
    #1;
    check("rd8000_bus_out", {24'd0, bus.BUS_OUT}, 32'h7E);
    @(negedge Clk);
    cpu(1'b1, 16'h5000, 8'h00);
    #1;
`ifdef CPU_BUS_OPEN_BUS_EN
    check("rd5000_open_bus", {24'd0, bus.BUS_OUT}, 32'h7E);
`else
    check("rd5000_open_bus", {24'd0, bus.BUS_OUT}, 32'h00);
`endif
    @(negedge Clk);
    bus.CONTROL1 = 8'h01;
    cpu(1'b1, 16'h4016, 8'h00);
    #1;
`ifdef CPU_BUS_OPEN_BUS_EN
    check("rd4016_ctrl1", {24'd0, bus.BUS_OUT}, 32'h61);
`else
    check("rd4016_ctrl1", {24'd0, bus.BUS_OUT}, 32'h01);
`endif
    @(negedge Clk);

    // DMA from page $02, even then odd trigger cycle
    run_dma(0, "dma_even", 513);
    run_dma(1, "dma_odd", 514);

    // Reset in the middle of a transfer
    Reset = 1'b1;
    cpu(1'b1, 16'h0000, 8'h00);
    @(negedge Clk);
    Reset = 1'b0;
    cpu(1'b0, 16'h4014, 8'h02);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clk);
      if (i == 0) cpu(1'b1, 16'h1234, 8'h00);
      if (bus.OAM_WE === 1'b1 && bus.OAM_ADDR === 8'h40) begin
        found = 1'b1;
        break;
      end
    end
    check("abort_reached_idx40", {31'd0, found}, 32'd1);
    Reset = 1'b1;
    @(negedge Clk);
    check("abort_cpu_rdy", {31'd0, bus.CPU_RDY}, 32'd1);
    check("abort_oam_we", {31'd0, bus.OAM_WE}, 32'd0);
    check("abort_int_addr", {16'd0, bus.INT_ADDR}, 32'h1234);
    Reset      = 1'b0;
    oam_writes = 0;
    repeat (20) @(negedge Clk);
    check("abort_no_more_oam", oam_writes, 0);
    check("abort_rdy_stays", {31'd0, bus.CPU_RDY}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
